// File: rtl/access_mem_hs_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states, size decode.
package access_mem_hs_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_RESP = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } acc_size_e;

   // Unlisted funct3 codes fall through to a full-word access.
   function automatic acc_size_e access_size(input logic [2:0] f3);
      if (f3 == FUNCT3_LB || f3 == FUNCT3_LBU) return SZ_BYTE;
      if (f3 == FUNCT3_LH || f3 == FUNCT3_LHU) return SZ_HALF;
      return SZ_WORD;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated write data for stores,
// lane select plus sign/zero extension for loads.
module mem_lane_align
   import access_mem_hs_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int BE_W  = XLEN / 8,
   parameter int OFF_W = $clog2(BE_W)
) (
   input  logic [2:0]       funct3,
   input  logic [OFF_W-1:0] addr_lo,
   input  logic [XLEN-1:0]  st_data,
   input  logic [XLEN-1:0]  rd_data,
   output logic [BE_W-1:0]  be,
   output logic [XLEN-1:0]  wdata,
   output logic [XLEN-1:0]  ld_data
);

   logic [XLEN-1:0]  rd_sh;
   logic [OFF_W-1:0] half_off;
   logic             sext;

   always_comb begin
      be       = '0;
      wdata    = '0;
      ld_data  = '0;
      rd_sh    = '0;
      half_off = addr_lo & ~OFF_W'(1);
      sext     = ~funct3[2];
      case (access_size(funct3))
         SZ_BYTE: begin
            be    = BE_W'(1) << addr_lo;
            for (int i = 0; i < BE_W; i++) wdata[8*i +: 8] = st_data[7:0];
            rd_sh   = rd_data >> {addr_lo, 3'b000};
            ld_data = {{(XLEN-8){rd_sh[7] & sext}}, rd_sh[7:0]};
         end
         SZ_HALF: begin
            be    = BE_W'(2'b11) << half_off;
            for (int i = 0; i < BE_W; i++) wdata[8*i +: 8] = st_data[8*(i%2) +: 8];
            rd_sh   = rd_data >> {half_off, 3'b000};
            ld_data = {{(XLEN-16){rd_sh[15] & sext}}, rd_sh[15:0]};
         end
         default: begin
            be      = '1;
            wdata   = st_data;
            ld_data = rd_data;
         end
      endcase
   end

endmodule

// File: rtl/access_mem_hs.sv
// EX->WB memory stage with a req/gnt/rvalid data-memory handshake and upstream stall.
// Define LIGHT_MEM_MISALIGN_TRAP_EN to turn misaligned half/word accesses into a trapped bubble.
module access_mem_hs
   import access_mem_hs_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int BE_W   = XLEN / 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_pipe_Valid,
   input  logic [XLEN-1:0]   i_pipe_TargetAddr,
   input  logic [XLEN-1:0]   i_pipe_AluResult,
   input  logic              i_pipe_Zero,
   input  logic [2:0]        i_pipe_Funct3,
   input  logic              i_pipe_MemRd,
   input  logic              i_pipe_MemWrEn,
   input  logic              i_pipe_MemToReg,
   input  logic              i_pipe_RegWrEn,
   input  logic              i_pipe_Branch,
   input  logic              i_pipe_Jump,
   input  logic [XLEN-1:0]   i_pipe_Reg2Data,
   input  logic [REG_AW-1:0] i_pipe_RegDst,
   input  logic              i_forward_Slct,
   input  logic [XLEN-1:0]   i_forward_Data,
   output logic              o_ctl_NextPC,
   output logic [XLEN-1:0]   o_ctl_TargetAddr,
   output logic              o_ctl_Stall,
   output logic              o_dmem_Req,
   output logic              o_dmem_We,
   output logic [XLEN-1:0]   o_dmem_Addr,
   output logic [BE_W-1:0]   o_dmem_Be,
   output logic [XLEN-1:0]   o_dmem_WData,
   input  logic              i_dmem_Gnt,
   input  logic              i_dmem_RValid,
   input  logic [XLEN-1:0]   i_dmem_RData,
   output logic [XLEN-1:0]   o_pipe_MemData,
   output logic [XLEN-1:0]   o_pipe_AluResult,
   output logic [REG_AW-1:0] o_pipe_RegDst,
   output logic              o_pipe_MemToReg,
   output logic              o_pipe_RegWrEn,
   output logic              o_misalign
);

   localparam int OFF_W = $clog2(BE_W);

   mem_state_e      state;
   logic            req_q;
   logic            misalign_q;
   logic            mem_op;
   logic            misalign;
   logic            done;
   logic            wb_load;
   logic [XLEN-1:0] st_data;
   logic [BE_W-1:0] be;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] ld_data;

   assign mem_op  = i_pipe_Valid & (i_pipe_MemRd | i_pipe_MemWrEn);
   assign st_data = i_forward_Slct ? i_forward_Data : i_pipe_Reg2Data;

`ifdef LIGHT_MEM_MISALIGN_TRAP_EN
   logic mis_addr;
   always_comb begin
      case (access_size(i_pipe_Funct3))
         SZ_HALF: mis_addr = i_pipe_AluResult[0];
         SZ_WORD: mis_addr = |i_pipe_AluResult[OFF_W-1:0];
         default: mis_addr = 1'b0;
      endcase
   end
   assign misalign = mem_op & mis_addr;
`else
   assign misalign = 1'b0;
`endif

   mem_lane_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align (
      .funct3  (i_pipe_Funct3),
      .addr_lo (i_pipe_AluResult[OFF_W-1:0]),
      .st_data (st_data),
      .rd_data (i_dmem_RData),
      .be      (be),
      .wdata   (wdata),
      .ld_data (ld_data)
   );

   // Upstream holds the stage inputs while stalled, so decode can stay combinational.
   always_comb begin
      done        = 1'b0;
      o_ctl_Stall = 1'b0;
      case (state)
         MEM_IDLE: if (mem_op && !misalign) o_ctl_Stall = 1'b1;
                   else                     done = i_pipe_Valid;
         MEM_REQ:  if (i_dmem_Gnt && i_pipe_MemWrEn) done = 1'b1;
                   else                              o_ctl_Stall = 1'b1;
         MEM_RESP: if (i_dmem_RValid) done = 1'b1;
                   else               o_ctl_Stall = 1'b1;
         default:  o_ctl_Stall = 1'b0;
      endcase
   end

   // Stores and trapped accesses retire as bubbles; only ALU ops and loads write back.
   assign wb_load = done && (state == MEM_RESP || (state == MEM_IDLE && !mem_op));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= MEM_IDLE;
         req_q <= 1'b0;
      end else begin
         case (state)
            MEM_IDLE: if (mem_op && !misalign) begin
               state <= MEM_REQ;
               req_q <= 1'b1;
            end
            MEM_REQ: if (i_dmem_Gnt) begin
               state <= i_pipe_MemWrEn ? MEM_IDLE : MEM_RESP;
               req_q <= 1'b0;
            end
            MEM_RESP: if (i_dmem_RValid) state <= MEM_IDLE;
            default: begin
               state <= MEM_IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_pipe_MemData   <= '0;
         o_pipe_AluResult <= '0;
         o_pipe_RegDst    <= '0;
         o_pipe_MemToReg  <= 1'b0;
         o_pipe_RegWrEn   <= 1'b0;
         misalign_q       <= 1'b0;
      end else begin
         misalign_q <= misalign && (state == MEM_IDLE);
         if (wb_load) begin
            o_pipe_MemData   <= (state == MEM_RESP) ? ld_data : '0;
            o_pipe_AluResult <= i_pipe_AluResult;
            o_pipe_RegDst    <= i_pipe_RegDst;
            o_pipe_MemToReg  <= i_pipe_MemToReg;
            o_pipe_RegWrEn   <= i_pipe_RegWrEn;
         end else begin
            o_pipe_MemData   <= '0;
            o_pipe_AluResult <= '0;
            o_pipe_RegDst    <= '0;
            o_pipe_MemToReg  <= 1'b0;
            o_pipe_RegWrEn   <= 1'b0;
         end
      end
   end

   assign o_misalign       = misalign_q;
   assign o_ctl_NextPC     = i_pipe_Valid & (i_pipe_Jump | (i_pipe_Branch & i_pipe_Zero));
   assign o_ctl_TargetAddr = i_pipe_TargetAddr;
   assign o_dmem_Req       = req_q;
   assign o_dmem_We        = req_q & i_pipe_MemWrEn;
   assign o_dmem_Addr      = req_q ? {i_pipe_AluResult[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign o_dmem_Be        = req_q ? be : '0;
   assign o_dmem_WData     = req_q ? wdata : '0;

endmodule
